// File: rtl/lc3b_types.sv
// Shared LC-3b core types: memory operation codes and memory-stage FSM states.
package lc3b_types;

    typedef enum logic [1:0] {
        OP_LOAD      = 2'd0,
        OP_STORE     = 2'd1,
        OP_LOAD_IND  = 2'd2,
        OP_STORE_IND = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_PTR  = 2'd1,
        MA_DATA = 2'd2,
        MA_RESP = 2'd3
    } mem_access_state_t;

    function automatic logic op_is_store(input mem_op_t op);
        return (op == OP_STORE) || (op == OP_STORE_IND);
    endfunction

    function automatic logic op_is_ind(input mem_op_t op);
        return (op == OP_LOAD_IND) || (op == OP_STORE_IND);
    endfunction

endpackage

// File: rtl/line_lane.sv
// Combinational lane steering between a word/byte access and a bus line:
// byte enables, write-line placement and read extraction (bytes zero-extended).
module line_lane #(
    parameter int WORD_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    localparam int LB        = LINE_WIDTH / 8,
    localparam int OFF       = $clog2(LB)
) (
    input  logic [OFF-1:0]        off,
    input  logic                  is_byte,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [LINE_WIDTH-1:0] dat_s,
    output logic [LB-1:0]         sel,
    output logic [LINE_WIDTH-1:0] dat_m,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [OFF-2:0] widx;

    always_comb begin
        widx = off[OFF-1:1];
        if (is_byte) begin
            sel   = LB'(1) << off;
            dat_m = LINE_WIDTH'(wdata[7:0]) << (8 * off);
            rdata = WORD_WIDTH'(dat_s[8*off +: 8]);
        end else begin
            // word accesses ignore address bit 0
            sel   = LB'(3) << {widx, 1'b0};
            dat_m = LINE_WIDTH'(wdata) << (WORD_WIDTH * widx);
            rdata = dat_s[WORD_WIDTH*widx +: WORD_WIDTH];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// LC-3b memory-stage access engine: word/byte and indirect loads/stores over a line-wide
// Wishbone port. Define MEM_ACCESS_MMIO_EN to map performance counters at MMIO_BASE.
module mem_access_unit
    import lc3b_types::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    WORD_WIDTH = 16,
    parameter int                    LINE_WIDTH = 128,
    parameter int                    NUM_CTRS   = 6,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 16'hFFE0,
    localparam int LINE_BYTES = LINE_WIDTH / 8,
    localparam int OFF        = $clog2(LINE_BYTES),
    localparam int LA_W       = ADDR_WIDTH - OFF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    input  mem_op_t                        req_op,
    input  logic                           req_byte,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [WORD_WIDTH-1:0]          req_wdata,
    output logic                           done,
    output logic [WORD_WIDTH-1:0]          resp_rdata,
    output logic [LA_W-1:0]                wb_adr,
    output logic [LINE_WIDTH-1:0]          wb_dat_m,
    input  logic [LINE_WIDTH-1:0]          wb_dat_s,
    output logic [LINE_BYTES-1:0]          wb_sel,
    output logic                           wb_we,
    output logic                           wb_stb,
    output logic                           wb_cyc,
    input  logic                           wb_ack,
    input  logic [NUM_CTRS*WORD_WIDTH-1:0] ctr_in
);

    mem_access_state_t     state_q, state_d;
    mem_op_t               op_q, op_d;
    logic                  byte_q, byte_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [LA_W-1:0]       adr_q, adr_d;
    logic [LINE_BYTES-1:0] sel_q, sel_d;
    logic [LINE_WIDTH-1:0] dat_m_q, dat_m_d;

    logic                  is_store;
    logic                  ack_seen;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [ADDR_WIDTH-1:0] phase_addr;
    logic                  lane_byte;
    logic [LINE_BYTES-1:0] lane_sel;
    logic [LINE_WIDTH-1:0] lane_dat_m;
    logic [WORD_WIDTH-1:0] lane_rdata;
    logic                  mmio_hit;
    logic [WORD_WIDTH-1:0] mmio_rdata;

    // After the pointer phase an indirect op behaves as a plain access at ptr_q.
    assign is_store   = op_is_store(op_q);
    assign ack_seen   = stb_q && wb_ack;
    assign data_addr  = op_is_ind(op_q) ? ptr_q : addr_q;
    assign phase_addr = (state_q == MA_PTR) ? addr_q : data_addr;
    assign lane_byte  = byte_q && (state_q != MA_PTR);

    line_lane #(
        .WORD_WIDTH (WORD_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_lane (
        .off     (phase_addr[OFF-1:0]),
        .is_byte (lane_byte),
        .wdata   (wdata_q),
        .dat_s   (wb_dat_s),
        .sel     (lane_sel),
        .dat_m   (lane_dat_m),
        .rdata   (lane_rdata)
    );

`ifdef MEM_ACCESS_MMIO_EN
    logic [ADDR_WIDTH:0] win_off;

    always_comb begin
        win_off    = {1'b0, data_addr} - {1'b0, MMIO_BASE};
        mmio_hit   = (state_q == MA_DATA) && (data_addr >= MMIO_BASE)
                     && (win_off < (ADDR_WIDTH+1)'(2 * NUM_CTRS));
        mmio_rdata = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (win_off[ADDR_WIDTH:1] == ADDR_WIDTH'(i)) begin
                mmio_rdata = ctr_in[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end
`else
    logic unused_ctr;

    assign mmio_hit   = 1'b0;
    assign mmio_rdata = '0;
    assign unused_ctr = ^{ctr_in, MMIO_BASE};
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        rdata_d = rdata_q;

        case (state_q)
            MA_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    byte_d  = req_byte;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = op_is_ind(req_op) ? MA_PTR : MA_DATA;
                end
            end
            MA_PTR: begin
                if (ack_seen) begin
                    ptr_d    = ADDR_WIDTH'(lane_rdata);
                    ptr_d[0] = 1'b0;
                    state_d  = MA_DATA;
                end
            end
            MA_DATA: begin
                if (mmio_hit) begin
                    if (!is_store) rdata_d = mmio_rdata;
                    state_d = MA_RESP;
                end else if (ack_seen) begin
                    if (!is_store) rdata_d = lane_rdata;
                    state_d = MA_RESP;
                end
            end
            MA_RESP: state_d = MA_IDLE;
            default: state_d = MA_IDLE;
        endcase

        // Strobe drops for at least one cycle after every ack, separating the two phases.
        stb_d   = ((state_q == MA_PTR) || ((state_q == MA_DATA) && !mmio_hit)) && !ack_seen;
        we_d    = stb_d && (state_q == MA_DATA) && is_store;
        adr_d   = stb_d ? phase_addr[ADDR_WIDTH-1:OFF] : '0;
        sel_d   = stb_d ? lane_sel : '0;
        dat_m_d = we_d ? lane_dat_m : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MA_IDLE;
            op_q    <= OP_LOAD;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_m_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_m_q <= dat_m_d;
        end
    end

    assign done       = (state_q == MA_RESP);
    assign resp_rdata = rdata_q;
    assign wb_stb     = stb_q;
    assign wb_cyc     = stb_q;
    assign wb_we      = we_q;
    assign wb_adr     = adr_q;
    assign wb_sel     = sel_q;
    assign wb_dat_m   = dat_m_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a line memory answers the Wishbone port with a
// programmable number of wait states and logs every acknowledged bus cycle.
module tb_mem_access_unit;
    import lc3b_types::*;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    mem_op_t       req_op;
    logic          req_byte;
    logic [15:0]   req_addr;
    logic [15:0]   req_wdata;
    logic          done;
    logic [15:0]   resp_rdata;
    logic [11:0]   wb_adr;
    logic [127:0]  wb_dat_m;
    logic [127:0]  wb_dat_s;
    logic [15:0]   wb_sel;
    logic          wb_we;
    logic          wb_stb;
    logic          wb_cyc;
    logic          wb_ack;
    logic [95:0]   ctr_in;

    logic          auto_ack;
    logic          manual_ack;
    int            wait_n;
    int            bus_cnt;
    logic [127:0]  line_mem [0:4095];
    logic [11:0]   log_adr   [0:63];
    logic [15:0]   log_sel   [0:63];
    logic          log_we    [0:63];
    logic [127:0]  log_dat_m [0:63];
    int            log_n;

    int            n_vec;
    int            n_err;

    assign wb_ack = auto_ack | manual_ack;

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .done       (done),
        .resp_rdata (resp_rdata),
        .wb_adr     (wb_adr),
        .wb_dat_m   (wb_dat_m),
        .wb_dat_s   (wb_dat_s),
        .wb_sel     (wb_sel),
        .wb_we      (wb_we),
        .wb_stb     (wb_stb),
        .wb_cyc     (wb_cyc),
        .wb_ack     (wb_ack),
        .ctr_in     (ctr_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus slave: ack after wait_n stalled strobe cycles, returning the addressed line.
    initial begin
        auto_ack = 1'b0;
        wb_dat_s = '0;
        bus_cnt  = 0;
        log_n    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (wb_stb && !auto_ack) begin
                if (bus_cnt == wait_n) begin
                    auto_ack         = 1'b1;
                    wb_dat_s         = line_mem[wb_adr];
                    log_adr[log_n]   = wb_adr;
                    log_sel[log_n]   = wb_sel;
                    log_we[log_n]    = wb_we;
                    log_dat_m[log_n] = wb_dat_m;
                    log_n            = (log_n + 1) % 64;
                    bus_cnt          = 0;
                end else begin
                    auto_ack = 1'b0;
                    bus_cnt  = bus_cnt + 1;
                end
            end else begin
                auto_ack = 1'b0;
                bus_cnt  = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and count edges until done; leaves time in the done cycle.
    task automatic do_req(input mem_op_t op, input logic b, input logic [15:0] a,
                          input logic [15:0] wd, input int exp_lat, input string tag,
                          input bit keep_valid);
        int lat;
        req_op    = op;
        req_byte  = b;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        lat = 0;
        while (lat < 40) begin
            step();
            lat = lat + 1;
            if (done) break;
        end
        chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        if (!keep_valid) req_valid = 1'b0;
    endtask

    initial begin
        int base;
        int cnt_done;
        int cnt_stb;
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = OP_LOAD;
        req_byte   = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        manual_ack = 1'b0;
        wait_n     = 0;
        ctr_in     = {16'h0006, 16'h0005, 16'h0004, 16'h0042, 16'h0002, 16'h0001};
        for (int i = 0; i < 4096; i++) line_mem[i] = '0;
        line_mem[3]  = 128'h7777_6666_5555_4444_BEEF_2222_1111_0000;
        line_mem[2]  = 128'h0000_0000_0000_0000_0000_0047_0000_0101;
        line_mem[16] = 128'h0000_0000_0000_0000_0000_0000_0000_CAFE;

        repeat (3) step();
        chk("rst_done",  128'(done),       128'(0));
        chk("rst_rdata", 128'(resp_rdata), 128'(0));
        chk("rst_stb",   128'(wb_stb),     128'(0));
        chk("rst_cyc",   128'(wb_cyc),     128'(0));
        chk("rst_we",    128'(wb_we),      128'(0));
        chk("rst_sel",   128'(wb_sel),     128'(0));
        chk("rst_adr",   128'(wb_adr),     128'(0));
        chk("rst_datm",  wb_dat_m,         128'(0));
        rst_n = 1'b1;
        step();

        // word load, one wait state
        wait_n = 1;
        base = log_n;
        do_req(OP_LOAD, 1'b0, 16'h0036, 16'h0000, 4, "ld_word", 0);
        chk("ld_word_rdata", 128'(resp_rdata), 128'(16'hBEEF));
        chk("ld_word_ncyc",  128'(log_n - base), 128'(1));
        chk("ld_word_adr",   128'(log_adr[base]), 128'(12'h003));
        chk("ld_word_sel",   128'(log_sel[base]), 128'(16'h00C0));
        chk("ld_word_we",    128'(log_we[base]),  128'(0));
        step();
        chk("ld_word_pulse", 128'(done), 128'(0));

        // byte store, no wait states
        wait_n = 0;
        base = log_n;
        do_req(OP_STORE, 1'b1, 16'h0013, 16'h12A5, 3, "st_byte", 0);
        chk("st_byte_rdata", 128'(resp_rdata), 128'(16'hBEEF));
        chk("st_byte_adr",   128'(log_adr[base]), 128'(12'h001));
        chk("st_byte_sel",   128'(log_sel[base]), 128'(16'h0008));
        chk("st_byte_we",    128'(log_we[base]),  128'(1));
        chk("st_byte_datm",  log_dat_m[base], 128'h0000_0000_0000_0000_0000_0000_A500_0000);
        step();
        chk("st_byte_pulse", 128'(done), 128'(0));

        // indirect load through pointer 0x0101
        base = log_n;
        do_req(OP_LOAD_IND, 1'b0, 16'h0020, 16'h0000, 5, "ldi", 0);
        chk("ldi_rdata",  128'(resp_rdata), 128'(16'hCAFE));
        chk("ldi_ncyc",   128'(log_n - base), 128'(2));
        chk("ldi_p_adr",  128'(log_adr[base]), 128'(12'h002));
        chk("ldi_p_sel",  128'(log_sel[base]), 128'(16'h0003));
        chk("ldi_d_adr",  128'(log_adr[(base+1)%64]), 128'(12'h010));
        chk("ldi_d_sel",  128'(log_sel[(base+1)%64]), 128'(16'h0003));
        step();

        // byte load, high byte of word 3 zero-extended
        base = log_n;
        do_req(OP_LOAD, 1'b1, 16'h0037, 16'h0000, 3, "ld_byte", 0);
        chk("ld_byte_rdata", 128'(resp_rdata), 128'(16'h00BE));
        chk("ld_byte_sel",   128'(log_sel[base]), 128'(16'h0080));
        step();

        // indirect store through pointer 0x0047 (bit 0 cleared -> 0x0046)
        base = log_n;
        do_req(OP_STORE_IND, 1'b0, 16'h0024, 16'h5A5A, 5, "sti", 0);
        chk("sti_rdata",  128'(resp_rdata), 128'(16'h00BE));
        chk("sti_p_sel",  128'(log_sel[base]), 128'(16'h0030));
        chk("sti_p_we",   128'(log_we[base]),  128'(0));
        chk("sti_d_adr",  128'(log_adr[(base+1)%64]), 128'(12'h004));
        chk("sti_d_sel",  128'(log_sel[(base+1)%64]), 128'(16'h00C0));
        chk("sti_d_we",   128'(log_we[(base+1)%64]),  128'(1));
        chk("sti_d_datm", log_dat_m[(base+1)%64], 128'h0000_0000_0000_0000_5A5A_0000_0000_0000);
        step();

        // reset during a data wait state, then a stray ack
        wait_n    = 50;
        req_op    = OP_LOAD;
        req_byte  = 1'b0;
        req_addr  = 16'h0036;
        req_valid = 1'b1;
        repeat (3) step();
        chk("rstw_stb_before", 128'(wb_stb), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("rstw_stb",   128'(wb_stb),     128'(0));
        chk("rstw_cyc",   128'(wb_cyc),     128'(0));
        chk("rstw_done",  128'(done),       128'(0));
        chk("rstw_rdata", 128'(resp_rdata), 128'(0));
        req_valid = 1'b0;
        step();
        rst_n  = 1'b1;
        wait_n = 0;
        step();
        manual_ack = 1'b1;
        step();
        manual_ack = 1'b0;
        cnt_done = 0;
        cnt_stb  = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) cnt_done = cnt_done + 1;
            if (wb_stb) cnt_stb = cnt_stb + 1;
        end
        chk("rstw_no_done", 128'(cnt_done), 128'(0));
        chk("rstw_no_stb",  128'(cnt_stb),  128'(0));

        do_req(OP_LOAD, 1'b0, 16'h0036, 16'h0000, 3, "after_rst", 0);
        chk("after_rst_rdata", 128'(resp_rdata), 128'(16'hBEEF));
        step();

        // back-to-back requests with req_valid held high
        do_req(OP_STORE, 1'b0, 16'h0040, 16'h1234, 3, "b2b_st", 1);
        do_req(OP_LOAD, 1'b0, 16'h0032, 16'h0000, 4, "b2b_ld", 0);
        chk("b2b_ld_rdata", 128'(resp_rdata), 128'(16'h1111));
        step();
        chk("b2b_pulse", 128'(done), 128'(0));

`ifdef MEM_ACCESS_MMIO_EN
        base = log_n;
        do_req(OP_LOAD, 1'b0, 16'hFFE4, 16'h0000, 2, "mmio_ld", 0);
        chk("mmio_rdata", 128'(resp_rdata), 128'(16'h0042));
        chk("mmio_nobus", 128'(log_n - base), 128'(0));
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised memory-stage access engine for the pipelined LC-3b core.
- Sits between the EX/MEM pipeline register and the Wishbone data port.
- Performs word/byte loads and stores, plus two-phase indirect (LDI/STI) accesses, on a line-wide bus.
- Its done pulse is the pipeline's proceed signal.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- WORD_WIDTH, 16, data word width.
- LINE_WIDTH, 128, Wishbone data width; must be a multiple of WORD_WIDTH; LINE_BYTES = LINE_WIDTH/8.
- NUM_CTRS, 6, number of memory-mapped performance counters (MMIO feature only).
- MMIO_BASE, 16'hFFE0, first byte address of the counter window (MMIO feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present; held stable until done.
- req_op  in  2  mem_op_t: OP_LOAD, OP_STORE, OP_LOAD_IND, OP_STORE_IND.
- req_byte  in  1  byte access (LDB/STB) when 1.
- req_addr  in  ADDR_WIDTH  effective address.
- req_wdata  in  WORD_WIDTH  store data (byte stores use [7:0]).
- done  out  1  one-cycle completion pulse.
- resp_rdata  out  WORD_WIDTH  load result, valid while done=1; bytes zero-extended.
- wb_adr  out  ADDR_WIDTH-log2(LINE_BYTES)  line address.
- wb_dat_m  out  LINE_WIDTH  write line.
- wb_dat_s  in  LINE_WIDTH  read line.
- wb_sel  out  LINE_BYTES  byte enables.
- wb_we, wb_stb, wb_cyc  out  1  bus controls.
- wb_ack  in  1  bus acknowledge.
- ctr_in  in  NUM_CTRS*WORD_WIDTH  counter values, counter i at slice i.

Behaviour:
- Reset (async, any state):
  - state=IDLE; done=0, resp_rdata=0, wb_stb=wb_cyc=wb_we=0, wb_sel=0, wb_adr=0, wb_dat_m=0, ptr_reg=0.
  - An outstanding bus cycle is abandoned; a late wb_ack is ignored.
- States: IDLE, PTR, DATA, RESP.
- IDLE:
  - On req_valid, latch op/byte/addr/wdata.
  - OP_LOAD_IND or OP_STORE_IND -> PTR.
  - Otherwise -> DATA.
  - wb_ack in IDLE is ignored.
- PTR:
  - Drive stb=cyc=1, we=0, word read at the latched address.
  - On ack, ptr_reg <= extracted word (bit0 forced 0) -> DATA using ptr_reg as address.
  - The operation becomes plain load/store.
- DATA:
  - Drive stb=cyc=1, we=1 for stores.
  - On ack, latch the read word/byte into resp_rdata (loads; stores leave it unchanged) -> RESP.
- RESP: done=1 for exactly one cycle -> IDLE. A new request is accepted on the following IDLE cycle, never in RESP.
- Bus outputs are registered.
- Latency: with ack in the first bus cycle, done = 3 cycles after request (plain) or 5 (indirect). Each wait state adds 1.
- Lane rules:
  - word index w = addr[log2(LINE_BYTES)-1:1], byte index b = addr[log2(LINE_BYTES)-1:0].
  - Word access: sel = 2'b11 << 2w; dat_m = wdata << WORD_WIDTH*w; addr bit0 ignored.
  - Byte access: sel = 1 << b; dat_m = wdata[7:0] << 8b.
  - Read: word = dat_s >> WORD_WIDTH*w; byte = zero-extended dat_s[8b+:8].
- req_valid dropping mid-operation: ignored; the operation completes.
- wb_ack may arrive in the same cycle stb first rises; the transition occurs that edge.

Optional Feature:
- Macro: MEM_ACCESS_MMIO_EN.
- With the macro: a word address in [MMIO_BASE, MMIO_BASE+2*NUM_CTRS) is a counter access; no bus cycle is issued.
  - Load returns ctr_in slice (addr-MMIO_BASE)/2 and goes directly to RESP, so done comes 2 cycles after request.
  - Store to the window is dropped and completes the same way.
  - Addresses in the window but ≥ NUM_CTRS read 0.
  - The decode applies to the final data address, including an indirect pointer that lands in the window; PTR reads always use the bus.
- Without the macro: the window does not exist, all addresses go to the bus, and ctr_in is unused.

Decomposition:
- lc3b_types gains mem_op_t and the mem_access_state_t enum.
- Sub-module line_lane: combinational word/byte extract and insert plus sel generation, instantiated once.

Test Plan:
- OP_LOAD word at addr 16'h0036, ack on the 2nd bus cycle, dat_s word 3 = 16'hBEEF:
  - wb_adr=12'h003, sel=16'h00C0 -> done 4 cycles after request, resp_rdata=16'hBEEF.
- OP_STORE byte at addr 16'h0013, wdata=16'h12A5, ack on the 1st bus cycle:
  - sel=16'h0008, we=1, dat_m[31:24]=8'hA5 -> done 3 cycles after request.
- OP_LOAD_IND at addr 16'h0020, pointer word 16'h0101:
  - PTR reads line 12'h002, then DATA reads addr 16'h0100 (bit0 cleared) -> done 5 cycles after request, no wait states.
- rst_n low during a DATA wait state, then wb_ack pulses after reset release:
  - stb/cyc drop immediately, state IDLE, no done pulse.
- MEM_ACCESS_MMIO_EN defined, OP_LOAD addr 16'hFFE4, ctr_in slice 2 = 16'h0042:
  - no stb, done 2 cycles after request, resp_rdata=16'h0042.
- Back-to-back OP_STORE then OP_LOAD with req_valid held high:
  - second request accepted only on the IDLE cycle after RESP; exactly one done pulse per request.
